// File: rtl/btn_evt_pkg.sv
// Shared types for the front-panel button event controller:
// event codes, per-button FSM states and a counter-width helper.
package btn_evt_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [CODE_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } btn_state_t;

  // Hold counter must reach the larger of the two tick limits.
  function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event output channel of the button controller.
// Handshake: the event {evt_btn, evt_code} transfers on a rising edge where
// evt_valid && evt_ready; while evt_valid is high and evt_ready low the
// producer holds evt_btn/evt_code stable, and evt_valid never drops without a transfer.
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  import btn_evt_pkg::*;

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic              evt_valid;
  logic              evt_ready;
  logic [IDX_W-1:0]  evt_btn;
  logic [CODE_W-1:0] evt_code;

  modport master (output evt_valid, output evt_btn, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_btn, input evt_code, output evt_ready);

endinterface

// File: rtl/btn_evt_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module btn_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced press/release pulses into PRESS/RELEASE/LONG/REPEAT events,
// arbitrates them round-robin into one event FIFO drained over a valid/ready channel.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [N_BTN-1:0]      btn_press,
  input  logic [N_BTN-1:0]      btn_release,
  button_event_ctrl_if.master   evt,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [N_BTN-1:0][1:0] dbg_state
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam int FW    = IDX_W + CODE_W;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] RPT_CNT   = CNT_W'(REPEAT_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BTN - 1);

  // Free-running prescaler shared by all buttons.
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (!RESET_N)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  logic [N_BTN-1:0] emit;
  evt_code_t        emit_code [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             emit_l;
    evt_code_t        code_l;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Release outranks a tick that would complete LONG/REPEAT in the same cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      emit_l  = 1'b0;
      code_l  = EVT_PRESS;
      case (state_q)
        ST_IDLE: begin
          if (btn_press[g] && !btn_release[g]) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            emit_l  = 1'b1;
            code_l  = EVT_PRESS;
          end
        end
        ST_HELD, ST_RPT: begin
          if (btn_release[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            emit_l  = 1'b1;
            code_l  = EVT_RELEASE;
          end else if (tick) begin
            cnt_d = cnt_inc;
            if (state_q == ST_HELD && cnt_inc == LONG_CNT) begin
              state_d = ST_RPT;
              cnt_d   = '0;
              emit_l  = 1'b1;
              code_l  = EVT_LONG;
            end else if (state_q == ST_RPT && cnt_inc == RPT_CNT) begin
              cnt_d  = '0;
              emit_l = 1'b1;
              code_l = EVT_REPEAT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign emit[g]      = emit_l;
    assign emit_code[g] = code_l;
    assign dbg_state[g] = state_q;
  end

  // Pending slots and round-robin arbiter.
  logic [N_BTN-1:0] slot_vld_q, slot_vld_d;
  evt_code_t        slot_code_q [N_BTN];
  evt_code_t        slot_code_d [N_BTN];
  logic [IDX_W-1:0] rr_q;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [N_BTN-1:0] grant_oh;
  logic             ovf_set;

  logic                       fifo_full, fifo_empty, fifo_pop, push_ok;
  logic [FW-1:0]              fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign fifo_pop = !fifo_empty && evt.evt_ready;
  assign push_ok  = !fifo_full || fifo_pop;

  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!grant_vld && push_ok && slot_vld_q[j]) begin
        grant_vld   = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_oh[j] = 1'b1;
      end
    end
  end

  // A granted slot can take a new event in the same cycle; otherwise a busy slot drops it,
  // except that RELEASE replaces a waiting REPEAT.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_code_d = slot_code_q;
    ovf_set     = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (grant_oh[i]) slot_vld_d[i] = 1'b0;
      if (emit[i]) begin
        if (!slot_vld_q[i] || grant_oh[i]) begin
          slot_vld_d[i]  = 1'b1;
          slot_code_d[i] = emit_code[i];
        end else begin
          ovf_set = 1'b1;
          if (emit_code[i] == EVT_RELEASE && slot_code_q[i] == EVT_REPEAT)
            slot_code_d[i] = EVT_RELEASE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      slot_vld_q <= '0;
      for (int i = 0; i < N_BTN; i++) slot_code_q[i] <= EVT_PRESS;
      rr_q     <= '0;
      overflow <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_code_q <= slot_code_d;
      if (grant_vld) rr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (grant_vld),
    .push_data ({grant_idx, slot_code_q[grant_idx]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt.evt_valid = (fifo_count != '0);
  assign evt.evt_btn   = fifo_empty ? '0 : fifo_head[FW-1:CODE_W];
  assign evt.evt_code  = fifo_empty ? '0 : fifo_head[CODE_W-1:0];

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: tick-based reference model feeds an expected
// queue, a monitor pops and compares every event the consumer accepts.
module tb_button_event_ctrl;
  import btn_evt_pkg::*;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LT = 3;
  localparam int RT = 2;
  localparam int FD = 4;
  localparam int IW = 2;
  localparam int EW = IW + 2;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic [N-1:0]   btn_press = '0;
  logic [N-1:0]   btn_release = '0;
  logic           clear_ovf = 1'b0;
  logic           overflow;
  logic [N-1:0][1:0] dbg_state;

  button_event_ctrl_if #(.N_BTN(N)) evt_if ();

  button_event_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .FIFO_DEPTH(FD)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .evt         (evt_if),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf),
    .dbg_state   (dbg_state)
  );

  // clock/reset
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got still running, required finished");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  bit  strict = 1'b1;
  int  ec = 0;
  bit  m_held [N];
  int  m_ticks [N];
  int  last_evt [N];
  bit  drop_next [N];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic model_emit(input int i, input evt_code_t code);
    logic [EW-1:0] e;
    last_evt[i] = ec;
    if (drop_next[i]) drop_next[i] = 1'b0;
    else begin
      e = {IW'(i), code};
      exp_q.push_back(e);
    end
  endtask

  // Reference model: ticks land on edges that are multiples of TD after reset;
  // LONG on the LT-th tick after PRESS, then REPEAT every RT ticks.
  initial begin
    for (int i = 0; i < N; i++) begin
      m_held[i] = 1'b0; m_ticks[i] = 0; last_evt[i] = -100; drop_next[i] = 1'b0;
    end
    forever begin
      @(posedge CLK);
      if (!RESET_N) begin
        ec = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
          m_held[i] = 1'b0; m_ticks[i] = 0; last_evt[i] = -100;
        end
      end else begin
        ec++;
        for (int i = 0; i < N; i++) begin
          if (m_held[i]) begin
            if (btn_release[i]) begin
              model_emit(i, EVT_RELEASE);
              m_held[i] = 1'b0;
            end else if (ec % TD == 0) begin
              m_ticks[i]++;
              if (m_ticks[i] == LT) model_emit(i, EVT_LONG);
              else if (m_ticks[i] > LT && (m_ticks[i] - LT) % RT == 0) model_emit(i, EVT_REPEAT);
            end
          end else if (btn_press[i] && !btn_release[i]) begin
            model_emit(i, EVT_PRESS);
            m_held[i]  = 1'b1;
            m_ticks[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: compare each accepted event against the expected queue.
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    int found;
    forever begin
      @(negedge CLK); #1;
      if (RESET_N && evt_if.evt_valid && evt_if.evt_ready) begin
        got = {evt_if.evt_btn, evt_if.evt_code};
        found = -1;
        if (strict) begin
          if (exp_q.size() != 0) found = 0;
        end else begin
          for (int k = 0; k < exp_q.size(); k++)
            if (found < 0 && exp_q[k][EW-1:2] == evt_if.evt_btn) found = k;
        end
        if (found < 0) begin
          n_chk++;
          $display("FAIL evt_unexpected: got btn %0d code %0d, required no event", evt_if.evt_btn, evt_if.evt_code);
        end else begin
          e = exp_q[found];
          exp_q.delete(found);
          chk(strict ? "evt_order" : "evt_per_btn", int'(got), int'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic [N-1:0] pm, input logic [N-1:0] rm);
    @(negedge CLK);
    btn_press = pm; btn_release = rm;
    @(negedge CLK);
    btn_press = '0; btn_release = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET_N = 1'b0;
    @(negedge CLK); RESET_N = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(negedge CLK); evt_if.evt_ready = r;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_if.evt_valid) && n < max_cyc) begin
      @(negedge CLK); n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int tp, first, target, n;
    logic [N-1:0] pm, rm;
    int r;
    evt_if.evt_ready = 1'b1;

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_btn", evt_if.evt_btn, 0);
    chk("rst_code", evt_if.evt_code, 0);
    chk("rst_ovf", overflow, 0);
    RESET_N = 1'b1;

    // 1: press/release on btn2, two-edge latency
    wait_cyc(6);
    pulse(4'b0100, 4'b0000);
    #1 chk("lat_press_early", evt_if.evt_valid, 0);
    @(negedge CLK); #1;
    chk("lat_press_valid", evt_if.evt_valid, 1);
    chk("lat_press_btn", evt_if.evt_btn, 2);
    chk("lat_press_code", evt_if.evt_code, EVT_PRESS);
    wait_cyc(1);
    pulse(4'b0000, 4'b0100);
    #1 chk("lat_rel_early", evt_if.evt_valid, 0);
    @(negedge CLK); #1;
    chk("lat_rel_valid", evt_if.evt_valid, 1);
    chk("lat_rel_code", evt_if.evt_code, EVT_RELEASE);
    drain(20);

    // 2: long hold on btn0 produces LONG then REPEATs
    pulse(4'b0001, 4'b0000);
    wait_cyc(30);
    pulse(4'b0000, 4'b0001);
    drain(20);

    // 3: all buttons at once from RR pointer 0, twice
    do_reset();
    pulse(4'b1111, 4'b0000);
    drain(20);
    chk("all_press_ovf", overflow, 0);
    pulse(4'b0000, 4'b1111);
    drain(20);

    // 4: backpressure, full FIFO, busy slot drops a new event
    set_ready(1'b0);
    pulse(4'b1111, 4'b0000);
    wait_cyc(5);
    #1;
    chk("stall_valid", evt_if.evt_valid, 1);
    chk("stall_btn", evt_if.evt_btn, 0);
    chk("stall_code", evt_if.evt_code, EVT_PRESS);
    pulse(4'b0000, 4'b1111);
    wait_cyc(1);
    drop_next[0] = 1'b1;
    pulse(4'b0001, 4'b0000);
    #1 chk("drop_ovf_set", overflow, 1);
    set_ready(1'b1);
    drain(30);
    chk("ovf_sticky", overflow, 1);
    @(negedge CLK); clear_ovf = 1'b1;
    @(negedge CLK); clear_ovf = 1'b0;
    #1 chk("ovf_cleared", overflow, 0);
    wait_cyc(10);
    pulse(4'b0000, 4'b0001);
    drain(20);

    // 5: release on the very tick that would complete LONG
    @(negedge CLK);
    btn_press = 4'b0010;
    tp = ec + 1;
    @(negedge CLK);
    btn_press = '0;
    first  = (tp / TD + 1) * TD;
    target = first + (LT - 1) * TD;
    n = 0;
    while (ec != target - 1 && n < 50) begin @(negedge CLK); n++; end
    chk("race_state_held", dbg_state[1], ST_HELD);
    btn_release = 4'b0010;
    @(negedge CLK);
    btn_release = '0;
    #1 chk("race_state_idle", dbg_state[1], ST_IDLE);
    drain(20);

    // 6: reset while btn0 repeats with queued events
    set_ready(1'b0);
    pulse(4'b0001, 4'b0000);
    n = 0;
    while (exp_q.size() < 2 && n < 60) begin @(negedge CLK); n++; end
    chk("pre_rst_queued", exp_q.size(), 2);
    wait_cyc(2);
    chk("pre_rst_state", dbg_state[0], ST_RPT);
    do_reset();
    chk("post_rst_valid", evt_if.evt_valid, 0);
    chk("post_rst_state", dbg_state[0], ST_IDLE);
    set_ready(1'b1);
    pulse(4'b0000, 4'b0001);
    wait_cyc(8);
    chk("ghost_release_valid", evt_if.evt_valid, 0);
    pulse(4'b0001, 4'b0000);
    wait_cyc(3);
    pulse(4'b0000, 4'b0001);
    drain(20);

    // random phase: per-button order against the model
    strict = 1'b0;
    repeat (900) begin
      @(negedge CLK);
      pm = '0; rm = '0;
      for (int i = 0; i < N; i++) begin
        if (ec + 1 - last_evt[i] >= 6) begin
          r = $urandom_range(0, 39);
          if (r < 4) pm[i] = 1'b1;
          else if (r < 8) rm[i] = 1'b1;
          else if (r == 8) begin pm[i] = 1'b1; rm[i] = 1'b1; end
        end
      end
      btn_press = pm; btn_release = rm;
    end
    repeat (60) begin
      @(negedge CLK);
      rm = '0;
      for (int i = 0; i < N; i++)
        if (m_held[i] && (ec + 1 - last_evt[i] >= 6)) rm[i] = 1'b1;
      btn_press = '0; btn_release = rm;
    end
    @(negedge CLK);
    btn_release = '0;
    drain(40);
    chk("rand_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Controller that sits behind a bank of N debouncers and turns their debounced press/release pulses into timed button events: PRESS, RELEASE, LONG and auto-REPEAT. A per-button FSM uses a shared millisecond-style tick. A round-robin arbiter moves events from the buttons into one event FIFO, which a consumer drains with a valid/ready handshake. This is the single point where UI logic reads the front-panel switches.

Parameters:
N_BTN, 4, number of buttons (debouncer instances) served; 2..8
TICK_DIV, 50000, CLK cycles per timing tick; >=2
LONG_TICKS, 500, ticks held after PRESS before LONG fires; >=1
REPEAT_TICKS, 100, ticks between REPEAT events after LONG; >=1
FIFO_DEPTH, 4, event FIFO entries; power of two, >=2

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous active-low reset
btn_press  in  N_BTN  one-cycle pulse per button: debounced level went 0->1
btn_release  in  N_BTN  one-cycle pulse per button: debounced level went 1->0
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_btn  out  clog2(N_BTN)  button index of head event
evt_code  out  2  0=PRESS 1=RELEASE 2=LONG 3=REPEAT
overflow  out  1  sticky: an event was dropped
clear_ovf  in  1  clears overflow (set wins if same cycle)

Behaviour:
- Reset (RESET_N=0 at an edge): all FSMs IDLE, hold counters 0, tick prescaler 0, pending slots empty, RR pointer 0, FIFO empty. Outputs evt_valid=0, evt_btn=0, evt_code=0, overflow=0. A reset mid-operation discards all in-flight and queued events. A button held through reset stays IDLE until its next btn_press, so no phantom events are produced.
- Tick: free-running counter 0..TICK_DIV-1. A tick pulse lasts one cycle when the counter equals TICK_DIV-1, after which the counter wraps to 0. The tick is shared by all buttons. Its phase is not aligned to presses, so the first interval may be short by up to TICK_DIV-1 cycles.
- Per-button FSM, states IDLE/HELD/RPT, with hold counter cnt (width clog2(max(LONG_TICKS,REPEAT_TICKS))+1):
  - IDLE: btn_press -> emit PRESS, cnt=0, go to HELD. btn_release is ignored.
  - HELD: on tick, cnt++. When the incremented value equals LONG_TICKS -> emit LONG, cnt=0, go to RPT.
  - RPT: on tick, cnt++. When it equals REPEAT_TICKS -> emit REPEAT, cnt=0, stay in RPT.
  - HELD/RPT: btn_release -> emit RELEASE, go to IDLE. Release has priority over a same-cycle tick expiry, so only RELEASE is emitted. btn_press in HELD/RPT is ignored.
  - btn_press and btn_release asserted together: treated as release if in HELD/RPT, ignored if in IDLE.
- Pending slot: one per button, {valid, code}. Emitting sets the slot. If the slot is already valid and not being granted this cycle, the new event is dropped and overflow is set. The exception is RELEASE, which overwrites a pending REPEAT; overflow is still set in that case.
- Arbiter: each cycle, grant at most one valid slot, searching from the RR pointer upward with wrap. The grant requires a FIFO push to be possible. On grant: push {index, code}, clear the slot, set RR pointer = granted+1 mod N_BTN. A slot may be granted and refilled in the same cycle.
- FIFO: show-ahead; evt_btn and evt_code are valid while evt_valid=1 and are held stable until popped. Pop occurs on evt_valid&&evt_ready. Push is allowed if count<FIFO_DEPTH or a pop happens in the same cycle. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: a pulse sampled at edge t sets the slot; with an uncontested arbiter and a non-full FIFO it is pushed at edge t+1; evt_valid=1 after edge t+1.

Decomposition:
- Package btn_evt_pkg: event code constants (EVT_PRESS..EVT_REPEAT), code width 2, FSM state encoding.
- Sub-module btn_evt_fifo: parameterised synchronous FIFO (width, depth) with full/empty/count.
- Tick prescaler, FSMs, pending slots and arbiter stay in the top module; FSMs are built with a generate loop.

Test Plan:
(All scenarios use N_BTN=4, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, FIFO_DEPTH=4, evt_ready=1 unless stated.)
1. btn_press[2] at cycle 10, btn_release[2] at cycle 14 -> FIFO output (2,PRESS) then (2,RELEASE); no LONG; each event visible 2 edges after its pulse.
2. btn_press[0] held for 30 cycles -> (0,PRESS); (0,LONG) on the 3rd tick after the press; (0,REPEAT) every 8 cycles thereafter; (0,RELEASE) on release.
3. btn_press[3:0]=4'b1111 in one cycle with RR pointer 0 -> events ordered btn 0,1,2,3, one per cycle; RR pointer ends at 0; overflow=0.
4. evt_ready=0; press all 4 buttons, then release all 4, then press btn0 again -> FIFO holds 4 PRESS events; slots hold 4 RELEASE events; the new btn0 event is dropped and overflow=1. With evt_ready=1, all 8 events drain in order. Pulsing clear_ovf then gives overflow=0.
5. btn_release[1] in the same cycle as the tick that completes LONG_TICKS -> only (1,RELEASE); FSM goes to IDLE.
6. RESET_N=0 for 1 cycle while btn0 is in RPT with 2 events queued -> evt_valid=0 after the reset edge; a later btn_release[0] produces nothing; the next btn_press[0] produces (0,PRESS).
